// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire bus arbiter: opcodes, FSM encoding,
// timeout default and a helper that sizes the timeout counter.
package onewire_pkg;

    localparam int TIMEOUT_CYC_DEFAULT = 10000000;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        ISSUE   = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        RECOVER = 3'd5
    } state_t;

    // Smallest width that can hold TIMEOUT_CYC-1; never narrower than 1 bit.
    function automatic int timer_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/onewire_op_timer.sv
// Per-operation timeout counter. It saturates at TIMEOUT_CYC-1 so it can
// never wrap before the compare.
module onewire_op_timer
    import onewire_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              W    = timer_width(TIMEOUT_CYC);
    localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count;

    // Count while enabled, restart on clear, hold at the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/onewire_bus_arbiter.sv
// Round-robin arbiter that shares one 1-Wire engine between two requesters
// (A = bit 0, B = bit 1) and sequences one byte operation at a time.
module onewire_bus_arbiter
    import onewire_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic       CLK_10MHZ,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] op_valid,
    input  logic [1:0] op_a,
    input  logic [1:0] op_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    output logic [7:0] rdata,
    output logic [1:0] op_done,
    output logic [1:0] op_err,
    output logic       ow_reset,
    output logic       ow_write,
    output logic       ow_read,
    output logic [7:0] ow_in_byte,
    input  logic [7:0] ow_out_byte,
    input  logic       ow_busy
);

    state_t     state, state_n;
    logic       owner, owner_n;
    logic       last_owner, last_owner_n;
    op_t        cur_op, cur_op_n;
    logic [1:0] gnt_n, op_done_n, op_err_n;
    logic       ow_reset_n, ow_write_n, ow_read_n;
    logic [7:0] ow_in_byte_n, rdata_n;
    logic       timer_clear, timer_en, expired;
    logic       winner;

    logic       owner_req, owner_valid;
    logic [1:0] owner_mask;
    op_t        owner_op;
    logic [7:0] owner_wdata;

    assign owner_req   = owner ? req[1]      : req[0];
    assign owner_valid = owner ? op_valid[1] : op_valid[0];
    assign owner_mask  = owner ? 2'b10       : 2'b01;
    assign owner_op    = owner ? op_t'(op_b) : op_t'(op_a);
    assign owner_wdata = owner ? wdata_b     : wdata_a;

    onewire_op_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (CLK_10MHZ),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(expired)
    );

    // State and all outputs are registered; reset abandons any operation.
    always_ff @(posedge CLK_10MHZ) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b1;
            last_owner <= 1'b1;
            cur_op     <= OP_RESET;
            gnt        <= '0;
            op_done    <= '0;
            op_err     <= '0;
            ow_reset   <= 1'b0;
            ow_write   <= 1'b0;
            ow_read    <= 1'b0;
            ow_in_byte <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            cur_op     <= cur_op_n;
            gnt        <= gnt_n;
            op_done    <= op_done_n;
            op_err     <= op_err_n;
            ow_reset   <= ow_reset_n;
            ow_write   <= ow_write_n;
            ow_read    <= ow_read_n;
            ow_in_byte <= ow_in_byte_n;
            rdata      <= rdata_n;
        end
    end

    // Next-state and output decisions; pulses default low, everything else holds.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        cur_op_n     = cur_op;
        gnt_n        = gnt;
        op_done_n    = '0;
        op_err_n     = '0;
        ow_reset_n   = ow_reset;
        ow_write_n   = ow_write;
        ow_read_n    = ow_read;
        ow_in_byte_n = ow_in_byte;
        rdata_n      = rdata;
        timer_clear  = 1'b0;
        timer_en     = (state == ISSUE) || (state == RUN);
        winner       = 1'b0;

        case (state)
            IDLE: begin
                gnt_n = '0;
                if (!ow_busy && (req != 2'b00)) begin
                    winner       = (req == 2'b11) ? ~last_owner : req[1];
                    owner_n      = winner;
                    last_owner_n = winner;
                    gnt_n        = winner ? 2'b10 : 2'b01;
                    state_n      = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end else if (owner_valid && ((op_err & owner_mask) == 2'b00)) begin
                    if (owner_op == OP_RSVD) begin
                        op_err_n = owner_mask;
                    end else begin
                        cur_op_n     = owner_op;
                        ow_reset_n   = (owner_op == OP_RESET);
                        ow_write_n   = (owner_op == OP_WRITE);
                        ow_read_n    = (owner_op == OP_READ);
                        ow_in_byte_n = owner_wdata;
                        timer_clear  = 1'b1;
                        state_n      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (expired) begin
                    ow_reset_n = 1'b0;
                    ow_write_n = 1'b0;
                    ow_read_n  = 1'b0;
                    op_err_n   = owner_mask;
                    state_n    = RECOVER;
                end else if (ow_busy) begin
                    ow_reset_n = 1'b0;
                    ow_write_n = 1'b0;
                    ow_read_n  = 1'b0;
                    state_n    = RUN;
                end
            end
            RUN: begin
                if (expired) begin
                    op_err_n = owner_mask;
                    state_n  = RECOVER;
                end else if (!ow_busy) begin
                    if (cur_op == OP_READ) begin
                        rdata_n = ow_out_byte;
                    end
                    op_done_n = owner_mask;
                    state_n   = DONE;
                end
            end
            DONE: begin
                state_n = GRANT;
            end
            RECOVER: begin
                if (!ow_busy) begin
                    state_n = GRANT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_onewire_bus_arbiter.sv
// Directed bench for onewire_bus_arbiter with a behavioural engine model and
// a scoreboard of expected done/err pulses.
module tb_onewire_bus_arbiter;

    localparam int MAIN_TIMEOUT  = 1000;
    localparam int SHORT_TIMEOUT = 100;

    logic       CLK_10MHZ = 1'b0;
    logic       reset;
    logic [1:0] req, op_valid, op_a, op_b;
    logic [7:0] wdata_a, wdata_b;
    logic [7:0] ow_out_byte = 8'h00;
    logic       ow_busy = 1'b0;

    logic [1:0] gnt, op_done, op_err;
    logic [7:0] rdata, ow_in_byte;
    logic       ow_reset, ow_write, ow_read;

    logic [1:0] t_gnt, t_op_done, t_op_err;
    logic [7:0] t_rdata, t_ow_in_byte;
    logic       t_ow_reset, t_ow_write, t_ow_read;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] done;
        logic [1:0] err;
        logic [7:0] data;
        logic       chk;
    } exp_t;
    exp_t sb_q[$];

    logic       engine_en;
    int         busy_delay, busy_hold;
    logic [7:0] read_byte;
    int         eng_phase = 0;
    int         eng_cnt   = 0;
    logic [1:0] prev_gnt  = 2'b00;

    // 10 MHz clock
    always #50 CLK_10MHZ = ~CLK_10MHZ;

    onewire_bus_arbiter #(.TIMEOUT_CYC(MAIN_TIMEOUT)) dut (
        .CLK_10MHZ  (CLK_10MHZ),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .wdata_a    (wdata_a),
        .wdata_b    (wdata_b),
        .rdata      (rdata),
        .op_done    (op_done),
        .op_err     (op_err),
        .ow_reset   (ow_reset),
        .ow_write   (ow_write),
        .ow_read    (ow_read),
        .ow_in_byte (ow_in_byte),
        .ow_out_byte(ow_out_byte),
        .ow_busy    (ow_busy)
    );

    onewire_bus_arbiter #(.TIMEOUT_CYC(SHORT_TIMEOUT)) dut_t (
        .CLK_10MHZ  (CLK_10MHZ),
        .reset      (reset),
        .req        (req),
        .gnt        (t_gnt),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .wdata_a    (wdata_a),
        .wdata_b    (wdata_b),
        .rdata      (t_rdata),
        .op_done    (t_op_done),
        .op_err     (t_op_err),
        .ow_reset   (t_ow_reset),
        .ow_write   (t_ow_write),
        .ow_read    (t_ow_read),
        .ow_in_byte (t_ow_in_byte),
        .ow_out_byte(ow_out_byte),
        .ow_busy    (ow_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_10MHZ);
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] v,
                                 input logic [1:0] oa, input logic [1:0] ob,
                                 input logic [7:0] wa, input logic [7:0] wb);
        req      = r;
        op_valid = v;
        op_a     = oa;
        op_b     = ob;
        wdata_a  = wa;
        wdata_b  = wb;
    endtask

    task automatic waitBusy(input logic level, input int bound, input string tag);
        int i = 0;
        while ((ow_busy !== level) && (i < bound)) begin
            cyc(1);
            i++;
        end
        checkOutput(tag, 32'(ow_busy), 32'(level));
    endtask

    task automatic waitPulse(input int bound, input string tag);
        int i = 0;
        while ((op_done == 2'b00) && (op_err == 2'b00) && (i < bound)) begin
            cyc(1);
            i++;
        end
        checkOutput(tag, 32'((op_done != 2'b00) || (op_err != 2'b00)), 32'd1);
    endtask

    // Engine model: busy rises busy_delay cycles after a strobe, holds busy_hold cycles.
    always @(negedge CLK_10MHZ) begin
        ow_out_byte = read_byte;
        case (eng_phase)
            0: if (engine_en && (ow_reset || ow_write || ow_read)) begin
                eng_phase = 1;
                eng_cnt   = busy_delay;
            end
            1: begin
                eng_cnt--;
                if (eng_cnt <= 0) begin
                    ow_busy   = 1'b1;
                    eng_phase = 2;
                    eng_cnt   = busy_hold;
                end
            end
            default: begin
                eng_cnt--;
                if (eng_cnt <= 0) begin
                    ow_busy   = 1'b0;
                    eng_phase = 0;
                end
            end
        endcase
    end

    // Scoreboard pop on every done/err pulse, plus per-cycle grant/strobe invariants.
    always @(negedge CLK_10MHZ) begin
        exp_t e;
        if (!reset) begin
            checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            checkOutput("strobe_exclusive", 32'($countones({ow_reset, ow_write, ow_read}) <= 1), 32'd1);
            if ((prev_gnt != 2'b00) && (gnt != 2'b00))
                checkOutput("gnt_no_switch", 32'(gnt), 32'(prev_gnt));
            if ((op_done != 2'b00) || (op_err != 2'b00)) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_unexpected_pulse", 32'({op_done, op_err}), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_done", 32'(op_done), 32'(e.done));
                    checkOutput("sb_err", 32'(op_err), 32'(e.err));
                    if (e.chk)
                        checkOutput("sb_rdata", 32'(rdata), 32'(e.data));
                end
            end
        end
        prev_gnt = gnt;
    end

    // Hard stop in case anything hangs.
    initial begin
        #(100 * 60000);
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
        int k;
        reset      = 1'b1;
        engine_en  = 1'b1;
        busy_delay = 40;
        busy_hold  = 600;
        read_byte  = 8'h00;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cyc(3);

        $display("[TB] reset values");
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(op_done), 32'd0);
        checkOutput("rst_err", 32'(op_err), 32'd0);
        checkOutput("rst_strobes", 32'({ow_reset, ow_write, ow_read}), 32'd0);
        checkOutput("rst_in_byte", 32'(ow_in_byte), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        cyc(1);

        $display("[TB] write 0xCC from A");
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cyc(1);
        checkOutput("t1_gnt", 32'(gnt), 32'd1);
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b00, 8'hCC, 8'h00);
        sb_q.push_back('{done: 2'b01, err: 2'b00, data: 8'h00, chk: 1'b0});
        cyc(1);
        checkOutput("t1_ow_write", 32'(ow_write), 32'd1);
        checkOutput("t1_in_byte", 32'(ow_in_byte), 32'hCC);
        waitBusy(1'b1, 100, "t1_busy_rise");
        cyc(1);
        checkOutput("t1_write_drop", 32'(ow_write), 32'd0);
        waitPulse(1000, "t1_pulse_seen");
        checkOutput("t1_done", 32'(op_done), 32'd1);
        op_valid = 2'b00;
        cyc(1);
        checkOutput("t1_done_one_cycle", 32'(op_done), 32'd0);

        $display("[TB] round-robin ties");
        reset = 1'b1;
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        checkOutput("t2_first_tie_a", 32'(gnt), 32'd1);
        req = 2'b10;
        cyc(1);
        checkOutput("t2_release_gap", 32'(gnt), 32'd0);
        cyc(1);
        checkOutput("t2_b_granted", 32'(gnt), 32'd2);
        req = 2'b00;
        cyc(1);
        checkOutput("t2_b_release", 32'(gnt), 32'd0);
        req = 2'b11;
        cyc(1);
        checkOutput("t2_second_tie_a", 32'(gnt), 32'd1);

        $display("[TB] read 0x5A from A with B op_valid ignored");
        busy_delay = 5;
        busy_hold  = 20;
        read_byte  = 8'h5A;
        applyStimulus(2'b11, 2'b11, 2'b10, 2'b01, 8'h00, 8'h77);
        sb_q.push_back('{done: 2'b01, err: 2'b00, data: 8'h5A, chk: 1'b1});
        cyc(1);
        checkOutput("t3_ow_read", 32'(ow_read), 32'd1);
        waitPulse(200, "t3_pulse_seen");
        checkOutput("t3_rdata", 32'(rdata), 32'h5A);
        checkOutput("t3_done_a_only", 32'(op_done), 32'd1);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cyc(1);
        checkOutput("t3_gnt_kept", 32'(gnt), 32'd1);

        $display("[TB] reserved opcode");
        applyStimulus(2'b01, 2'b01, 2'b11, 2'b00, 8'h00, 8'h00);
        sb_q.push_back('{done: 2'b00, err: 2'b01, data: 8'h00, chk: 1'b0});
        cyc(1);
        checkOutput("t4_err", 32'(op_err), 32'd1);
        checkOutput("t4_no_strobe", 32'({ow_reset, ow_write, ow_read}), 32'd0);
        op_valid = 2'b00;
        cyc(1);
        checkOutput("t4_err_one_cycle", 32'(op_err), 32'd0);
        checkOutput("t4_no_strobe_after", 32'({ow_reset, ow_write, ow_read}), 32'd0);

        $display("[TB] reset during RUN");
        busy_delay = 3;
        busy_hold  = 60;
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b00, 8'h3C, 8'h00);
        cyc(1);
        checkOutput("t5_ow_write", 32'(ow_write), 32'd1);
        waitBusy(1'b1, 50, "t5_busy_rise");
        cyc(3);
        reset    = 1'b1;
        op_valid = 2'b00;
        cyc(1);
        checkOutput("t5_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("t5_rst_pulses", 32'({op_done, op_err}), 32'd0);
        checkOutput("t5_rst_strobes", 32'({ow_reset, ow_write, ow_read}), 32'd0);
        checkOutput("t5_rst_in_byte", 32'(ow_in_byte), 32'd0);
        checkOutput("t5_rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        k = 0;
        while ((ow_busy === 1'b1) && (k < 100)) begin
            checkOutput("t5_no_grant_while_busy", 32'(gnt), 32'd0);
            cyc(1);
            k++;
        end
        checkOutput("t5_busy_fall", 32'(ow_busy), 32'd0);
        cyc(2);
        checkOutput("t5_gnt_after_busy", 32'(gnt), 32'd1);

        $display("[TB] timeout with silent engine");
        engine_en = 1'b0;
        reset     = 1'b1;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        checkOutput("t6_gnt", 32'(t_gnt), 32'd1);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 8'h96, 8'h00);
        cyc(1);
        checkOutput("t6_strobe", 32'({t_ow_reset, t_ow_write, t_ow_read}), 32'd4);
        checkOutput("t6_in_byte", 32'(t_ow_in_byte), 32'h96);
        k = 0;
        while ((t_op_err == 2'b00) && (k < 150)) begin
            cyc(1);
            k++;
        end
        checkOutput("t6_err_latency", 32'(k), 32'(SHORT_TIMEOUT));
        checkOutput("t6_err_owner", 32'(t_op_err), 32'd1);
        checkOutput("t6_strobe_dropped", 32'({t_ow_reset, t_ow_write, t_ow_read}), 32'd0);
        checkOutput("t6_no_done", 32'(t_op_done), 32'd0);
        op_valid = 2'b00;
        cyc(1);
        checkOutput("t6_err_one_cycle", 32'(t_op_err), 32'd0);
        applyStimulus(2'b01, 2'b01, 2'b11, 2'b00, 8'h00, 8'h00);
        cyc(1);
        checkOutput("t6_back_in_grant", 32'(t_op_err), 32'd1);
        checkOutput("t6_rdata_untouched", 32'(t_rdata), 32'd0);
        op_valid = 2'b00;
        reset    = 1'b1;
        cyc(2);

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/onewire_bus_arbiter.md
ONEWIRE_BUS_ARBITER -- requirements
Module: onewire_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10000000, is the per-operation timeout in clock cycles (1 s at 10 MHz).
REQ-002 CLK_10MHZ  in  1  sole clock; the block has one clock, and all logic is on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  bus request per requester; bit 0 = A, bit 1 = B; a requester holds it high for its whole 1-Wire transaction.
REQ-005 gnt  out  2  one-hot grant; at most one bit high.
REQ-006 op_valid  in  2  per-requester byte-operation request, level, held until op_done or op_err.
REQ-007 op_a, op_b  in  2 each  opcode: 00 bus reset, 01 write byte, 10 read byte, 11 reserved.
REQ-008 wdata_a, wdata_b  in  8 each  write byte for each requester.
REQ-009 rdata  out  8  last read byte, shared between requesters, valid when op_done pulses.
REQ-010 op_done  out  2  1-cycle completion pulse to the owner.
REQ-011 op_err  out  2  1-cycle error pulse to the owner, for a timeout or a reserved opcode.
REQ-012 ow_reset, ow_write, ow_read  out  1 each  strobes to the shared one_wire engine.
REQ-013 ow_in_byte  out  8  write byte to the engine.
REQ-014 ow_out_byte  in  8  read byte from the engine.
REQ-015 ow_busy  in  1  engine busy; it may rise up to 60 cycles after a strobe because the engine runs on a divided clock.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, ISSUE, RUN, DONE and RECOVER.
REQ-017 In IDLE, with ow_busy=0 and at least one req high, the block SHALL select an owner and assert its gnt bit on the next cycle while entering GRANT.
REQ-018 Arbitration SHALL be round-robin: if both req are high, the requester that was not the last owner wins; last_owner resets to B, so A wins the first tie.
REQ-019 In GRANT, if the owner's req is low, gnt SHALL clear and the FSM SHALL enter IDLE next cycle; release wins over a simultaneous op_valid, and that operation is dropped.
REQ-020 In GRANT, for owner op_valid=1 with op in 00/01/10, the block SHALL drive the matching ow_* strobe high, drive ow_in_byte=wdata of the owner, and enter ISSUE.
REQ-021 In GRANT, for opcode 11, the block SHALL pulse op_err to the owner next cycle, leave the engine untouched, and stay in GRANT.
REQ-022 op_valid and opcodes from the non-owner SHALL be ignored, with no pulses to it.
REQ-023 In ISSUE, the strobe SHALL be held until ow_busy=1 is seen, then dropped in the same registered update while the FSM enters RUN.
REQ-024 In RUN, when ow_busy=0 is seen, the block SHALL capture ow_out_byte into rdata for reads only, and enter DONE.
REQ-025 DONE SHALL pulse op_done for the owner for exactly 1 cycle, then return to GRANT.
REQ-026 The timeout counter SHALL clear on entry to ISSUE and count in ISSUE and RUN.
REQ-027 When the counter reaches TIMEOUT_CYC-1, the block SHALL drop all strobes, pulse op_err to the owner, and enter RECOVER.
REQ-028 RECOVER SHALL wait for ow_busy=0, then enter GRANT.
REQ-029 The counter width SHALL be the minimum needed for TIMEOUT_CYC, with no wrap-around before the compare.
REQ-030 A req drop by the owner during ISSUE/RUN/RECOVER SHALL NOT abort the operation; release is evaluated only in GRANT.
REQ-031 Grant SHALL NOT change owner without passing through IDLE, and gnt SHALL have no one-cycle overlap between requesters.
REQ-032 Within one operation, at most one of ow_reset/ow_write/ow_read SHALL be high at any time.

Reset
REQ-033 On reset=1, the block SHALL set state=IDLE, gnt=0, op_done=0, op_err=0, ow_reset/ow_write/ow_read=0, ow_in_byte=0, rdata=0, timeout counter=0 and last_owner=B.
REQ-034 Reset mid-operation SHALL abandon the operation without any done/err pulse; the engine is not reset by this block, and IDLE withholds grants until ow_busy=0.

Structure
REQ-035 Package onewire_pkg SHALL hold the opcode constants (OP_RESET, OP_WRITE, OP_READ, OP_RSVD), the FSM state encoding, and the TIMEOUT_CYC default.
REQ-036 Sub-module onewire_op_timer (clear, enable, expired) SHALL implement the timeout counter; the arbitration and FSM stay in onewire_bus_arbiter.

Verification
REQ-037 req=01; A issues write 0xCC; engine model raises busy 40 cycles after ow_write and holds it 600 cycles -> gnt=01 one cycle after req, ow_in_byte=0xCC, ow_write drops when busy rises, op_done=01 for 1 cycle after busy falls.
REQ-038 req=11 from reset -> A granted first; A drops req -> gnt=00 for ≥1 cycle, then gnt=10; second tie after B's release -> A granted.
REQ-039 A owns the bus and reads, model returns 0x5A -> rdata=0x5A during the op_done pulse; a B op_valid during this is ignored.
REQ-040 TIMEOUT_CYC=100, engine never raises busy -> strobe drops and op_err=01 exactly 100 cycles after ISSUE entry, then GRANT.
REQ-041 Opcode 11 from the owner -> op_err pulse and no ow_* strobe; reset asserted during RUN with busy high -> all outputs at reset values, and no grant until busy=0.
